// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the sequential ALU:
//   alu_op_e    - 4-bit opcode encoding (1100-1111 are undefined)
//   alu_state_e - control FSM states
//   FLAG_*      - bit positions inside the 3-bit {overflow, negative, zero} flags
//   is_shift_op - helper that recognises the three iterative shift opcodes
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W      = 4;
    localparam int FLAG_W    = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_INC   = 4'b0101,
        OP_PASSA = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_SHL   = 4'b1000,
        OP_SHR   = 4'b1001,
        OP_ASR   = 4'b1010,
        OP_MUL   = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Operand/result bus of the sequential ALU.
//   in_valid/in_ready   - request handshake (operands a, b and opcode)
//   out_valid/out_ready - result handshake (out and {ovf, neg, zero} flags)
// Modports:
//   master - the producer/consumer side (register-file read / write-back)
//   slave  - the ALU side
// -----------------------------------------------------------------------------
interface alu_if
    import alu_pkg::*;
#(
    parameter int BW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     in_a;
    logic [BW-1:0]     in_b;
    logic [OP_W-1:0]   opcode;
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     out;
    logic [FLAG_W-1:0] flags;

    modport master (
        output in_valid, in_a, in_b, opcode, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, in_a, in_b, opcode, out_ready,
        output in_ready, out_valid, out, flags
    );
endinterface

// File: rtl/alu_mc_unit.sv
// -----------------------------------------------------------------------------
// alu_mc_unit
// Iterative engine for the multi-cycle operations:
//   SHL/SHR/ASR - one bit per cycle, down-counter loaded with the amount
//   MUL         - BW shift-add iterations on a 2*BW accumulator
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   i_start     - load operands and begin (only asserted while idle)
//   i_op        - opcode (shift or MUL)
//   i_a, i_b    - operands; shift amount is i_b[SHAMT_W-1:0] (must be > 0)
//   o_done      - high in the last iteration cycle; o_result/o_overflow are
//                 then the final values and may be registered on that edge
//   o_result    - low BW bits of the result
//   o_overflow  - MUL only: upper BW bits of the product are non-zero
// -----------------------------------------------------------------------------
module alu_mc_unit
    import alu_pkg::*;
#(
    parameter int BW      = 16,
    parameter int SHAMT_W = $clog2(BW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [OP_W-1:0] i_op,
    input  logic [BW-1:0]   i_a,
    input  logic [BW-1:0]   i_b,
    output logic            o_done,
    output logic [BW-1:0]   o_result,
    output logic            o_overflow
);
    // One extra bit so the counter can hold BW for the multiplier.
    localparam int CNT_W = SHAMT_W + 1;

    logic              r_busy;
    logic [OP_W-1:0]   r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [BW-1:0]     r_data;   // shift operand, or multiplier for MUL
    logic [2*BW-1:0]   r_mcand;  // multiplicand, shifted left each step
    logic [2*BW-1:0]   r_acc;

    logic              w_is_mul;
    logic              w_last;
    logic [BW-1:0]     w_shift_next;
    logic [2*BW-1:0]   w_acc_next;

    assign w_is_mul = (r_op == OP_MUL);
    assign w_last   = r_busy && (r_cnt == CNT_W'(1));

    always_comb begin
        w_shift_next = r_data;
        case (r_op)
            OP_SHL:  w_shift_next = {r_data[BW-2:0], 1'b0};
            OP_SHR:  w_shift_next = {1'b0, r_data[BW-1:1]};
            OP_ASR:  w_shift_next = {r_data[BW-1], r_data[BW-1:1]};
            default: w_shift_next = r_data;
        endcase
    end

    assign w_acc_next = r_acc + (r_data[0] ? r_mcand : '0);

    // The final step is computed combinationally so the top can register the
    // result on the same edge the counter reaches zero.
    assign o_done     = w_last;
    assign o_result   = w_is_mul ? w_acc_next[BW-1:0] : w_shift_next;
    assign o_overflow = w_is_mul && (|w_acc_next[2*BW-1:BW]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_op   <= i_op;
            r_acc  <= '0;
            if (i_op == OP_MUL) begin
                r_cnt   <= CNT_W'(BW);
                r_data  <= i_b;
                r_mcand <= {{BW{1'b0}}, i_a};
            end else begin
                r_cnt   <= {1'b0, i_b[SHAMT_W-1:0]};
                r_data  <= i_a;
                r_mcand <= '0;
            end
        end else if (r_busy) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_busy <= !w_last;
            if (w_is_mul) begin
                r_acc   <= w_acc_next;
                r_mcand <= {r_mcand[2*BW-2:0], 1'b0};
                r_data  <= {1'b0, r_data[BW-1:1]};
            end else begin
                r_data  <= w_shift_next;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Clocked ALU between register-file read and write-back. Single-cycle ops
// (ADD/SUB/AND/OR/XOR/INC/PASS A/PASS B, shifts by 0, undefined opcodes)
// produce a result one cycle after acceptance; shifts by N>0 take N+1 cycles
// and MUL takes BW+1 cycles via alu_mc_unit.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (aborts any operation in flight)
//   bus  - alu_if.slave: in_valid/in_ready/in_a/in_b/opcode,
//          out_valid/out_ready/out/flags ({overflow, negative, zero})
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int BW      = 16,
    parameter int SHAMT_W = $clog2(BW)
) (
    input logic   clk,
    input logic   rst,
    alu_if.slave  bus
);
    alu_state_e        r_state;
    logic [BW-1:0]     r_out;
    logic [FLAG_W-1:0] r_flags;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_go_mc;
    logic              w_mc_start;
    logic              w_mc_done;
    logic [BW-1:0]     w_mc_result;
    logic              w_mc_ovf;
    logic [BW-1:0]     w_sum;
    logic [BW-1:0]     w_diff;
    logic [BW-1:0]     w_inc;
    logic [BW-1:0]     w_sc_res;
    logic              w_sc_ovf;

    function automatic logic [FLAG_W-1:0] make_flags(input logic [BW-1:0] res,
                                                     input logic          ovf);
        logic [FLAG_W-1:0] f;
        f            = '0;
        f[FLAG_OVF]  = ovf;
        f[FLAG_NEG]  = res[BW-1];
        f[FLAG_ZERO] = (res == '0);
        return f;
    endfunction

    // Ready also while DONE is being drained, so a new op can follow with no bubble.
    assign bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.flags     = r_flags;

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_go_mc    = (bus.opcode == OP_MUL) ||
                        (is_shift_op(bus.opcode) && (bus.in_b[SHAMT_W-1:0] != '0));
    assign w_mc_start = w_accept && w_go_mc;

    assign w_sum  = bus.in_a + bus.in_b;
    assign w_diff = bus.in_a - bus.in_b;
    assign w_inc  = bus.in_a + BW'(1);

    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (bus.in_a[BW-1] == bus.in_b[BW-1]) &&
                           (w_sum[BW-1] != bus.in_a[BW-1]);
            end
            OP_SUB: begin
                w_sc_res = w_diff;
                w_sc_ovf = (bus.in_a[BW-1] != bus.in_b[BW-1]) &&
                           (w_diff[BW-1] != bus.in_a[BW-1]);
            end
            OP_AND:   w_sc_res = bus.in_a & bus.in_b;
            OP_OR:    w_sc_res = bus.in_a | bus.in_b;
            OP_XOR:   w_sc_res = bus.in_a ^ bus.in_b;
            OP_INC: begin
                w_sc_res = w_inc;
                w_sc_ovf = w_inc[BW-1] && !bus.in_a[BW-1];
            end
            OP_PASSA: w_sc_res = bus.in_a;
            OP_PASSB: w_sc_res = bus.in_b;
            // Shifts only take this path when the amount is zero.
            OP_SHL, OP_SHR, OP_ASR: w_sc_res = bus.in_a;
            default: begin
                w_sc_res = '0;
                w_sc_ovf = 1'b0;
            end
        endcase
    end

    alu_mc_unit #(
        .BW      (BW),
        .SHAMT_W (SHAMT_W)
    ) u_mc (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_mc_start),
        .i_op       (bus.opcode),
        .i_a        (bus.in_a),
        .i_b        (bus.in_b),
        .o_done     (w_mc_done),
        .o_result   (w_mc_result),
        .o_overflow (w_mc_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (w_go_mc) begin
                            r_state     <= EXEC;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_out       <= w_sc_res;
                            r_flags     <= make_flags(w_sc_res, w_sc_ovf);
                        end
                    end else if ((r_state == DONE) && bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                EXEC: begin
                    if (w_mc_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out       <= w_mc_result;
                        r_flags     <= make_flags(w_mc_result, w_mc_ovf);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, parametrised successor to the combinational 16-bit ALU.
- Keeps the same 8 single-cycle opcodes and the {overflow, negative, zero} flags.
- Adds multi-cycle shifts and a shift-add multiplier, registered outputs and valid/ready handshakes on both sides.
- Sits between the register-file read stage and write-back in the datapath.

Parameters:
- BW, 16, operand and result width in bits; must be a power of 2, at least 4.
- SHAMT_W, $clog2(BW), width of the shift amount taken from in_b.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  BW  operand A, unsigned vector.
- in_b  in  BW  operand B; for shifts, the amount is in_b[SHAMT_W-1:0].
- opcode  in  4  operation select.
- out_valid  out  1  out and flags hold a result.
- out_ready  in  1  consumer takes the result.
- out  out  BW  registered result.
- flags  out  3  registered {overflow, negative, zero}.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 OR, 0100 XOR, 0101 INC (a+1), 0110 PASS A, 0111 PASS B.
  - 1000 SHL, 1001 SHR (logical), 1010 ASR.
  - 1011 MUL: low BW bits of unsigned a*b.
  - 1100-1111 undefined: out=0, flags=3'b001.
- Flags:
  - negative = out[BW-1]; zero = (out==0).
  - overflow = signed two's-complement overflow for ADD/SUB/INC.
  - overflow = (upper BW bits of the 2*BW product != 0) for MUL.
  - overflow = 0 for all other opcodes.
- FSM states IDLE, EXEC, DONE.
  - IDLE: in_ready=1. A handshake occurs when in_valid & in_ready; operands and opcode are latched.
  - Single-cycle op, or shift with amount 0: go to DONE. Result and flags are registered the same edge, so out_valid rises 1 cycle after acceptance.
  - Shift with amount N>0: go to EXEC. One bit per cycle, down-counter loaded with N; go to DONE on the edge where the count reaches 0. Latency N+1.
  - MUL: go to EXEC. BW shift-add iterations on a 2*BW accumulator; latency BW+1.
  - EXEC: in_ready=0, out_valid=0. Inputs are ignored.
  - DONE: out_valid=1; out and flags are held stable until out_ready.
    - out_ready=1 with in_valid=0: go to IDLE.
    - out_ready=1 with in_valid=1: in_ready=1, and the new operation is accepted in the same cycle (back-to-back, no bubble).
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready, which is allowed.
- Reset:
  - On rst=1 at an edge: state=IDLE, out=0, flags=3'b000, out_valid=0, counter and accumulator cleared.
  - Applies from any state, including mid-EXEC. The aborted result is never presented.
  - in_ready=1 in the first cycle after reset deasserts.
- out and flags are don't-care while out_valid=0, but must not change while in DONE.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_op_e (all opcodes above).
  - typedef enum alu_state_e {IDLE, EXEC, DONE}.
  - localparams FLAG_OVF=2, FLAG_NEG=1, FLAG_ZERO=0.
- One sub-module alu_mc_unit:
  - Holds the iterative shifter/multiplier: operand registers, down-counter, 2*BW accumulator.
  - Interface: start, done, op, a, b, result, overflow.
- Top alu_seq holds the FSM, the handshake, the single-cycle combinational path and the flag generation.

Test Plan (BW=16):
- ADD 0x7FFF+0x0001, out_ready=1 -> out=0x8000, flags=3'b110, out_valid 1 cycle after accept. SUB 0x000F-0x000F -> 0x0000, flags=3'b001.
- SHL 0x0001 by 4 -> 0x0010, flags=000, out_valid 5 cycles after accept. SHL by 0 -> 0x0001 with latency 1. in_ready=0 throughout EXEC.
- ASR 0x8000 by 15 -> 0xFFFF, flags=3'b010. SHR 0x8000 by 15 -> 0x0001, flags=000.
- MUL 0x0003*0x0005 -> 0x000F, flags=000, latency 17. MUL 0x0100*0x0100 -> 0x0000, flags=3'b101.
- Backpressure: out_ready=0 for 3 cycles in DONE -> out/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0x000F^0xF000) -> accepted that cycle, next result 0xF00F, flags=3'b010.
- rst=1 for 1 cycle mid-MUL (cycle 8 of EXEC) -> next cycle out_valid=0, in_ready=1, out=0, flags=0; a new ADD 0x0002+0x0002 -> 0x0004.
